// File: rtl/id_ex_register_pkg.sv
// Shared types for the ID/EX pipeline register: control bundle, ALU operation classes.
// The all-zero control word is the bubble (NOP) injected on stall or flush.
package id_ex_register_pkg;

  localparam int DATA_W_DEFAULT = 32;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  typedef struct packed {
    logic       reg_dst;
    logic       branch_eq;
    logic       branch_ne;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_register_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones instead of wrapping.
// One cycle from inc/clr to count; clear wins over increment.
module sat_counter
  import id_ex_register_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: loads every edge, 1-cycle latency, no hold path.
// Stall or flush squashes the control word to a bubble; data fields still load.
module id_ex_register
  import id_ex_register_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegDst,
  input  logic              Branch_eq,
  input  logic              Branch_ne,
  input  logic              MemtoReg,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              ALUSrc,
  input  logic              RegWrite,
  input  logic [1:0]        ALUOp,
  input  logic              Stall,
  input  logic              ID_Flush,
  input  logic [DATA_W-1:0] IF_ID_PC4,
  input  logic [DATA_W-1:0] IF_ID_ReadData1,
  input  logic [DATA_W-1:0] IF_ID_ReadData2,
  input  logic [DATA_W-1:0] IF_ID_SignExtImm,
  input  logic [4:0]        IF_ID_RegisterRs,
  input  logic [4:0]        IF_ID_RegisterRt,
  input  logic [4:0]        IF_ID_RegisterRd,
  input  logic [5:0]        IF_ID_Funct,
  input  logic              stat_clr,
  output logic              ID_EX_RegDst,
  output logic              ID_EX_Branch_eq,
  output logic              ID_EX_Branch_ne,
  output logic              ID_EX_MemtoReg,
  output logic              ID_EX_MemRead,
  output logic              ID_EX_MemWrite,
  output logic              ID_EX_ALUSrc,
  output logic              ID_EX_RegWrite,
  output logic [1:0]        ID_EX_ALUOp,
  output logic [DATA_W-1:0] ID_EX_PC4,
  output logic [DATA_W-1:0] ID_EX_ReadData1,
  output logic [DATA_W-1:0] ID_EX_ReadData2,
  output logic [DATA_W-1:0] ID_EX_SignExtImm,
  output logic [4:0]        ID_EX_RegisterRs,
  output logic [4:0]        ID_EX_RegisterRt,
  output logic [4:0]        ID_EX_RegisterRd,
  output logic [5:0]        ID_EX_Funct,
  output logic              ID_EX_Valid,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  ctrl_t             w_ctrl_in;
  logic              w_bubble;
  ctrl_t             r_ctrl;
  logic              r_valid;
  logic [DATA_W-1:0] r_pc4;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_imm;
  logic [4:0]        r_rs;
  logic [4:0]        r_rt;
  logic [4:0]        r_rd;
  logic [5:0]        r_funct;

  assign w_ctrl_in = '{reg_dst: RegDst, branch_eq: Branch_eq, branch_ne: Branch_ne,
                       mem_to_reg: MemtoReg, mem_read: MemRead, mem_write: MemWrite,
                       alu_src: ALUSrc, reg_write: RegWrite, alu_op: ALUOp};
  assign w_bubble  = Stall | ID_Flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ctrl  <= CTRL_NOP;
      r_valid <= 1'b0;
      r_pc4   <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_imm   <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
      r_funct <= '0;
    end else begin
      // A bubble clears MemRead too, so hazard detection never re-stalls on it.
      r_ctrl  <= w_bubble ? CTRL_NOP : w_ctrl_in;
      r_valid <= ~w_bubble;
      r_pc4   <= IF_ID_PC4;
      r_rd1   <= IF_ID_ReadData1;
      r_rd2   <= IF_ID_ReadData2;
      r_imm   <= IF_ID_SignExtImm;
      r_rs    <= IF_ID_RegisterRs;
      r_rt    <= IF_ID_RegisterRt;
      r_rd    <= IF_ID_RegisterRd;
      r_funct <= IF_ID_Funct;
    end
  end

  assign ID_EX_RegDst     = r_ctrl.reg_dst;
  assign ID_EX_Branch_eq  = r_ctrl.branch_eq;
  assign ID_EX_Branch_ne  = r_ctrl.branch_ne;
  assign ID_EX_MemtoReg   = r_ctrl.mem_to_reg;
  assign ID_EX_MemRead    = r_ctrl.mem_read;
  assign ID_EX_MemWrite   = r_ctrl.mem_write;
  assign ID_EX_ALUSrc     = r_ctrl.alu_src;
  assign ID_EX_RegWrite   = r_ctrl.reg_write;
  assign ID_EX_ALUOp      = r_ctrl.alu_op;
  assign ID_EX_Valid      = r_valid;
  assign ID_EX_PC4        = r_pc4;
  assign ID_EX_ReadData1  = r_rd1;
  assign ID_EX_ReadData2  = r_rd2;
  assign ID_EX_SignExtImm = r_imm;
  assign ID_EX_RegisterRs = r_rs;
  assign ID_EX_RegisterRt = r_rt;
  assign ID_EX_RegisterRd = r_rd;
  assign ID_EX_Funct      = r_funct;

  // Flush takes the accounting when both hazards coincide.
  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (Stall & ~ID_Flush),
    .clr   (stat_clr),
    .cnt   (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ID_Flush),
    .clr   (stat_clr),
    .cnt   (flush_cnt)
  );

endmodule
